// File: rtl/wb_fetch_if.sv
// Fetch unit connections: Wishbone classic read bus toward memories plus the instruction stream,
// redirect and fault signals toward the core. master = fetch unit, slave = memory/core environment.
interface wb_fetch_if #(
  parameter int ADR_WIDTH = 64,
  parameter int DAT_WIDTH = 64
);
  logic [ADR_WIDTH-1:0] fetch_adr_o;
  logic [DAT_WIDTH-1:0] fetch_dat_i;
  logic                 fetch_we_o;
  logic                 fetch_cyc_o;
  logic                 fetch_stb_o;
  logic                 fetch_ack_i;
  logic                 fetch_err_i;
  logic [DAT_WIDTH-1:0] insn_o;
  logic [ADR_WIDTH-1:0] insn_adr_o;
  logic                 insn_valid_o;
  logic                 insn_ready_i;
  logic                 redirect_i;
  logic [ADR_WIDTH-1:0] redirect_adr_i;
  logic                 fault_o;
  logic [ADR_WIDTH-1:0] fault_adr_o;
  logic                 fault_timeout_o;

  modport master (
    output fetch_adr_o, fetch_we_o, fetch_cyc_o, fetch_stb_o,
    input  fetch_dat_i, fetch_ack_i, fetch_err_i,
    output insn_o, insn_adr_o, insn_valid_o,
    input  insn_ready_i, redirect_i, redirect_adr_i,
    output fault_o, fault_adr_o, fault_timeout_o
  );

  modport slave (
    input  fetch_adr_o, fetch_we_o, fetch_cyc_o, fetch_stb_o,
    output fetch_dat_i, fetch_ack_i, fetch_err_i,
    input  insn_o, insn_adr_o, insn_valid_o,
    output insn_ready_i, redirect_i, redirect_adr_i,
    input  fault_o, fault_adr_o, fault_timeout_o
  );
endinterface

// File: rtl/wb_fetch.sv
// Wishbone classic instruction-fetch master: at most one read per 3 cycles, reads stall while the FIFO is full (insn_ready_i low).
// Defining WB_FETCH_TIMEOUT_EN adds a watchdog that faults a bus cycle left unanswered for TIMEOUT cycles.
module wb_fetch #(
  parameter int                   ADR_WIDTH  = 64,
  parameter int                   DAT_WIDTH  = 64,
  parameter logic [ADR_WIDTH-1:0] RESET_PC   = 64'h8000_0000_0000_0000,
  parameter int                   FIFO_DEPTH = 2,
  parameter int                   TIMEOUT    = 16
) (
  input logic        clk_i,
  input logic        rst_i,
  wb_fetch_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADR_WIDTH-1:0] STEP       = ADR_WIDTH'(DAT_WIDTH / 8);
  localparam logic [ADR_WIDTH-1:0] ALIGN_MASK = ~(STEP - ADR_WIDTH'(1));

  typedef enum logic [1:0] {IDLE, BUS, GAP} state_t;

  typedef struct packed {
    logic [ADR_WIDTH-1:0] adr;
    logic [DAT_WIDTH-1:0] dat;
  } entry_t;

  state_t               state;
  logic                 cyc, stb, discard;
  logic [ADR_WIDTH-1:0] adr, pc, fault_adr;
  logic                 fault, fault_tmo;
  entry_t               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 valid, push, pop, tmo_hit;

`ifdef WB_FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == BUS) && (tmo_cnt == TMO_W'(TIMEOUT - 1)) &&
                   !bus.fetch_ack_i && !bus.fetch_err_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              tmo_cnt <= '0;
    else if (state == IDLE) tmo_cnt <= '0;
    else if (state == BUS)  tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign valid = (count != '0);
  assign pop   = valid && bus.insn_ready_i;
  // A fetch still in flight when a redirect arrives is completed on the bus but never buffered.
  assign push  = (state == BUS) && bus.fetch_ack_i && !bus.fetch_err_i && !discard && !bus.redirect_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cyc       <= 1'b0;
      stb       <= 1'b0;
      adr       <= RESET_PC;
      pc        <= RESET_PC;
      discard   <= 1'b0;
      fault     <= 1'b0;
      fault_adr <= '0;
      fault_tmo <= 1'b0;
    end else begin
      if (bus.redirect_i) begin
        pc        <= bus.redirect_adr_i & ALIGN_MASK;
        fault     <= 1'b0;
        fault_adr <= '0;
        fault_tmo <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!bus.redirect_i && !fault && (count < CNT_W'(FIFO_DEPTH))) begin
            state <= BUS;
            cyc   <= 1'b1;
            stb   <= 1'b1;
            adr   <= pc;
          end
        end
        BUS: begin
          if (bus.fetch_ack_i || bus.fetch_err_i || tmo_hit) begin
            state   <= GAP;
            cyc     <= 1'b0;
            stb     <= 1'b0;
            discard <= 1'b0;
            if (!discard && !bus.redirect_i) begin
              if (bus.fetch_err_i || tmo_hit) begin
                fault     <= 1'b1;
                fault_adr <= pc;
                fault_tmo <= tmo_hit;
              end else begin
                pc <= pc + STEP;
              end
            end
          end else if (bus.redirect_i) begin
            discard <= 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{adr: pc, dat: bus.fetch_dat_i};
  end

  assign bus.fetch_adr_o     = adr;
  assign bus.fetch_we_o      = 1'b0;
  assign bus.fetch_cyc_o     = cyc;
  assign bus.fetch_stb_o     = stb;
  assign bus.insn_o          = mem[rd_ptr].dat;
  assign bus.insn_adr_o      = mem[rd_ptr].adr;
  assign bus.insn_valid_o    = valid;
  assign bus.fault_o         = fault;
  assign bus.fault_adr_o     = fault_adr;
  assign bus.fault_timeout_o = fault_tmo;
endmodule
